pc_stack: RTL and testbench
===========================

# pc_stack

Parametrised program counter with a hardware return-address stack. It extends the basic 16-bit load/inc/reset counter with configurable width, reset vector and increment step, PC-relative jumps, and call/return support. It sits in the CPU fetch path, driving the instruction-memory address. It is the planned replacement for the fixed 16-bit PC when subroutine support is added.

## Interface
Parameters:
- WIDTH, 16: PC and address width in bits (≥2).
- DEPTH, 8: return-stack entries (≥1).
- RESET_VALUE, 0: value loaded into out on reset.
- STEP, 1: increment applied by inc and pushed by call.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- reset_n  input  1  active-low reset, synchronous to clk (sampled only on the rising edge).
- in  input  WIDTH  absolute target for load/call.
- offset  input  WIDTH  two's-complement displacement for jrel.
- load  input  1  absolute jump.
- call  input  1  push return address, jump to in.
- ret  input  1  pop return address into out.
- jrel  input  1  relative jump.
- inc  input  1  advance by STEP.
- out  output  WIDTH  current PC, registered.
- depth  output  $clog2(DEPTH+1)  number of valid stack entries.
- overflow  output  1  sticky: a call was issued while the stack was full.
- underflow  output  1  sticky: a ret was issued while the stack was empty.

## Operation
- One command executes per cycle, chosen by fixed priority: reset_n=0 > load > call > ret > jrel > inc > hold. Lower-priority strobes asserted in the same cycle are ignored entirely and have no side effects.
- reset_n=0: out←RESET_VALUE, depth←0, overflow←0, underflow←0. Stack RAM contents are don't-care and must never be observable.
- load: out←in. Stack is untouched.
- call, depth<DEPTH: push (out+STEP) mod 2^WIDTH, depth+1, out←in.
- call, depth==DEPTH: out←in, nothing pushed, depth unchanged, overflow←1. Existing entries are preserved.
- ret, depth>0: out←top entry, depth−1.
- ret, depth==0: out holds, underflow←1.
- jrel: out←(out+offset) mod 2^WIDTH. offset is signed, so 0xFFFF with WIDTH=16 moves back one.
- inc: out←(out+STEP) mod 2^WIDTH. Wrap-around is silent.
- hold (no strobe): all state unchanged.
- Stack is LIFO. Stale entries above depth are never returned.
- overflow and underflow clear only on reset.
- All arithmetic is WIDTH bits, modulo 2^WIDTH. No carry out.

## Timing
- Every output is a register driven directly from flops. There is no combinational path from inputs to outputs.
- Latency is one cycle: a command sampled at edge N is visible on out, depth and the flags after edge N.
- Back-to-back commands are supported every cycle. Examples:
  - call then ret on consecutive cycles returns to the caller's out+STEP.
  - ret then call on consecutive cycles reuses the freed slot.
- Reset asserted mid-sequence, including on the same edge as call or ret, wins outright. No push or pop occurs.
- Reset values: out=RESET_VALUE, depth=0, overflow=0, underflow=0, held for every cycle reset_n is low.
- The first command is accepted on the first edge with reset_n=1.

## Test plan
- Reset/priority (WIDTH=16): reset_n=0 with load=1, in=0x1234 → out=0x0000, depth=0. Then load=1, inc=1, in=0x1234 → out=0x1234. Then inc → 0x1235.
- Wrap and relative jump: load 0xFFFF, then inc → 0x0000. Then jrel with offset=0xFFFE → 0xFFFE. Then jrel with offset=0x0010 → 0x000E.
- Nested call/ret (DEPTH=2), starting at out=0x0100:
  - call in=0x0200 → out=0x0200, depth=1.
  - call in=0x0300 → out=0x0300, depth=2.
  - ret → 0x0201, depth=1.
  - ret → 0x0101, depth=0.
- Overflow (DEPTH=2, full stack holding 0x0101, 0x0201, out=0x0300): call in=0x0400 → out=0x0400, depth=2, overflow=1. Then ret → 0x0201. overflow stays 1 until reset.
- Underflow: from reset, ret → out=0x0000, underflow=1, depth=0. Then inc → 0x0001, underflow still 1.
- Simultaneous events:
  - call=1 and ret=1 with in=0x0050 at out=0x0010 → call wins: out=0x0050, top=0x0011.
  - reset_n=0 together with call → depth=0, out=RESET_VALUE.

Source files
------------

// File: rtl/pc_stack.sv
// Program counter with load, increment, PC-relative jump and a hardware
// return-address stack for call/ret. All outputs come straight from flops.
module pc_stack #(
  parameter int unsigned WIDTH       = 16,
  parameter int unsigned DEPTH       = 8,
  parameter int unsigned RESET_VALUE = 0,
  parameter int unsigned STEP        = 1
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic [WIDTH-1:0]             in,
  input  logic [WIDTH-1:0]             offset,
  input  logic                         load,
  input  logic                         call,
  input  logic                         ret,
  input  logic                         jrel,
  input  logic                         inc,
  output logic [WIDTH-1:0]             out,
  output logic [$clog2(DEPTH+1)-1:0]   depth,
  output logic                         overflow,
  output logic                         underflow
);

  localparam int unsigned DW = $clog2(DEPTH + 1);
  localparam int unsigned IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam logic [WIDTH-1:0] RST_PC     = WIDTH'(RESET_VALUE);
  localparam logic [WIDTH-1:0] STEP_W     = WIDTH'(STEP);
  localparam logic [DW-1:0]    DEPTH_FULL = DW'(DEPTH);

  logic [WIDTH-1:0] out_q, out_d;
  logic [DW-1:0]    depth_q, depth_d;
  logic             overflow_q, overflow_d;
  logic             underflow_q, underflow_d;

  // Stack RAM is never reset; only entries below depth_q are ever read.
  logic [WIDTH-1:0] mem_q [2**IW];

  logic             push_en;
  logic [IW-1:0]    push_idx;
  logic [IW-1:0]    pop_idx;
  logic [WIDTH-1:0] push_data;

  always_comb begin
    out_d       = out_q;
    depth_d     = depth_q;
    overflow_d  = overflow_q;
    underflow_d = underflow_q;
    push_en     = 1'b0;
    push_idx    = IW'(depth_q);
    pop_idx     = IW'(depth_q - DW'(1));
    push_data   = out_q + STEP_W;

    if (load) begin
      out_d = in;
    end else if (call) begin
      out_d = in;
      if (depth_q < DEPTH_FULL) begin
        push_en = 1'b1;
        depth_d = depth_q + DW'(1);
      end else begin
        overflow_d = 1'b1;
      end
    end else if (ret) begin
      if (depth_q != '0) begin
        out_d   = mem_q[pop_idx];
        depth_d = depth_q - DW'(1);
      end else begin
        underflow_d = 1'b1;
      end
    end else if (jrel) begin
      out_d = out_q + offset;
    end else if (inc) begin
      out_d = out_q + STEP_W;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      out_q       <= RST_PC;
      depth_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      out_q       <= out_d;
      depth_q     <= depth_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  // Reset suppresses the push so a call on the reset edge leaves no trace.
  always_ff @(posedge clk) begin
    if (reset_n && push_en) begin
      mem_q[push_idx] <= push_data;
    end
  end

  assign out       = out_q;
  assign depth     = depth_q;
  assign overflow  = overflow_q;
  assign underflow = underflow_q;

endmodule

// File: tb/tb_pc_stack.sv
// Directed bench for pc_stack (WIDTH=16, DEPTH=2): a queue-based reference
// model checked every cycle, plus literal expectations from worked examples.
module tb_pc_stack;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [15:0] in, offset;
  logic        load, call, ret, jrel, inc;
  logic [15:0] out;
  logic [1:0]  depth;
  logic        overflow, underflow;

  int checks   = 0;
  int failures = 0;

  logic [15:0] m_out;
  logic [15:0] m_stk[$];
  logic        m_ovf, m_unf;
  bit          chk_en = 1'b0;

  pc_stack #(
    .WIDTH(16),
    .DEPTH(2),
    .RESET_VALUE(0),
    .STEP(1)
  ) dut (
    .clk(clk), .reset_n(reset_n), .in(in), .offset(offset),
    .load(load), .call(call), .ret(ret), .jrel(jrel), .inc(inc),
    .out(out), .depth(depth), .overflow(overflow), .underflow(underflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("model_out", 32'(out), 32'(m_out));
      check("model_depth", 32'(depth), 32'(m_stk.size()));
      check("model_ovf", 32'(overflow), 32'(m_ovf));
      check("model_unf", 32'(underflow), 32'(m_unf));
    end
  end

  // Apply one cycle of inputs, advance the model on the same edge.
  task automatic step(input logic r, input logic ld, input logic c, input logic rt,
                      input logic jr, input logic ic,
                      input logic [15:0] i, input logic [15:0] off);
    reset_n = r; load = ld; call = c; ret = rt; jrel = jr; inc = ic;
    in = i; offset = off;
    @(posedge clk);
    if (!r) begin
      m_out = 16'h0000; m_stk.delete(); m_ovf = 1'b0; m_unf = 1'b0;
    end else if (ld) begin
      m_out = i;
    end else if (c) begin
      if (m_stk.size() < 2) m_stk.push_back(m_out + 16'd1);
      else m_ovf = 1'b1;
      m_out = i;
    end else if (rt) begin
      if (m_stk.size() > 0) m_out = m_stk.pop_back();
      else m_unf = 1'b1;
    end else if (jr) begin
      m_out = m_out + off;
    end else if (ic) begin
      m_out = m_out + 16'd1;
    end
    #1;
    chk_en = 1'b1;
  endtask

  task automatic do_load(input logic [15:0] v);  step(1, 1, 0, 0, 0, 0, v, 0);  endtask
  task automatic do_call(input logic [15:0] v);  step(1, 0, 1, 0, 0, 0, v, 0);  endtask
  task automatic do_ret();                       step(1, 0, 0, 1, 0, 0, 0, 0);  endtask
  task automatic do_jrel(input logic [15:0] o);  step(1, 0, 0, 0, 1, 0, 0, o);  endtask
  task automatic do_inc();                       step(1, 0, 0, 0, 0, 1, 0, 0);  endtask
  task automatic do_hold();                      step(1, 0, 0, 0, 0, 0, 0, 0);  endtask

  initial begin
    m_out = '0; m_ovf = 1'b0; m_unf = 1'b0;

    // Reset beats load
    step(0, 1, 0, 0, 0, 1, 16'h1234, 0);
    step(0, 1, 0, 0, 0, 1, 16'h1234, 0);
    check("rst_out", 32'(out), 32'h0000);
    check("rst_depth", 32'(depth), 32'd0);
    check("rst_flags", 32'({overflow, underflow}), 32'd0);

    // load beats inc
    step(1, 1, 0, 0, 0, 1, 16'h1234, 0);
    check("load_prio", 32'(out), 32'h1234);
    do_inc();
    check("inc", 32'(out), 32'h1235);

    // Wrap and relative jumps
    do_load(16'hFFFF);
    do_inc();
    check("wrap_inc", 32'(out), 32'h0000);
    do_jrel(16'hFFFE);
    check("jrel_back", 32'(out), 32'hFFFE);
    do_jrel(16'h0010);
    check("jrel_fwd_wrap", 32'(out), 32'h000E);

    // Nested call/ret
    do_load(16'h0100);
    do_call(16'h0200);
    check("call1_out", 32'(out), 32'h0200);
    check("call1_depth", 32'(depth), 32'd1);
    do_call(16'h0300);
    check("call2_out", 32'(out), 32'h0300);
    check("call2_depth", 32'(depth), 32'd2);
    do_ret();
    check("ret1_out", 32'(out), 32'h0201);
    do_ret();
    check("ret2_out", 32'(out), 32'h0101);
    check("ret2_depth", 32'(depth), 32'd0);

    // Overflow keeps existing entries
    do_load(16'h0100);
    do_call(16'h0200);
    do_call(16'h0300);
    do_call(16'h0400);
    check("ovf_out", 32'(out), 32'h0400);
    check("ovf_depth", 32'(depth), 32'd2);
    check("ovf_flag", 32'(overflow), 32'd1);
    do_ret();
    check("ovf_ret", 32'(out), 32'h0201);
    do_ret();
    check("ovf_ret2", 32'(out), 32'h0101);
    do_hold();
    do_hold();
    check("ovf_sticky", 32'(overflow), 32'd1);
    check("hold_out", 32'(out), 32'h0101);

    // Underflow
    step(0, 0, 0, 0, 0, 0, 0, 0);
    do_ret();
    check("unf_out", 32'(out), 32'h0000);
    check("unf_flag", 32'(underflow), 32'd1);
    do_inc();
    check("unf_inc", 32'(out), 32'h0001);
    check("unf_sticky", 32'(underflow), 32'd1);

    // call beats ret
    do_load(16'h0010);
    step(1, 0, 1, 1, 0, 0, 16'h0050, 0);
    check("callret_out", 32'(out), 32'h0050);
    check("callret_depth", 32'(depth), 32'd1);
    do_ret();
    check("callret_top", 32'(out), 32'h0011);

    // Back-to-back call/ret and slot reuse
    do_call(16'h0600);
    do_ret();
    check("b2b_ret", 32'(out), 32'h0012);
    do_call(16'h0700);
    do_ret();
    check("b2b_reuse", 32'(out), 32'h0013);

    // Reset on the same edge as call / ret
    do_call(16'h0800);
    step(0, 0, 1, 0, 0, 0, 16'h0999, 0);
    check("rst_call_out", 32'(out), 32'h0000);
    check("rst_call_depth", 32'(depth), 32'd0);
    check("rst_clr_flags", 32'({overflow, underflow}), 32'd0);
    do_call(16'h0A00);
    step(0, 0, 0, 1, 0, 0, 0, 0);
    check("rst_ret_depth", 32'(depth), 32'd0);
    do_ret();
    check("stale_hidden", 32'(out), 32'h0000);
    check("stale_unf", 32'(underflow), 32'd1);
    do_hold();

    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
